mips_multicycle_control: RTL and testbench

- Main sequencing FSM for the multicycle MIPS datapath.
- Steps each instruction through fetch, decode, execute, memory and write-back.
- Drives the datapath strobes and the 2-bit ALU-op class consumed by the ALU control decoder.
- Handles memory wait states, a freeze/enable input and a HALT instruction, and counts retired instructions for the debug path.

---
 rtl/mips_multicycle_control.sv | 206 ++++++++++++++++++++
 tb/tb_mips_multicycle_control.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_control.sv
// Main sequencing FSM for the multicycle MIPS datapath.
// Steps each instruction through FETCH, DECODE, EXEC, MEM and WB, drives the
// datapath strobes and the 2-bit ALU-op class, handles memory wait states,
// a freeze input and HALT, and counts retired instructions.
//
// Ports:
//   i_clk, i_reset      clock, synchronous active-high reset
//   i_start             leave IDLE and begin fetching
//   i_enable            1 = FSM advances, 0 = frozen (strobes forced low)
//   i_opcode            opcode field of the instruction register
//   i_mem_ready         memory completes the current access this cycle
//   o_pc_write .. o_jump  datapath strobes
//   o_aluop             ALU class: 00 LW/SW, 01 BEQ, 10 R-type, 11 I-type ALU
//   o_state             current state (debug)
//   o_halted            HALT reached
//   o_invalid           one-cycle pulse on an unsupported opcode
//   o_retired           retired-instruction count (wraps)
module mips_multicycle_control #(
  parameter int SIZEOP = 6,
  parameter int CNTW   = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_enable,
  input  logic [SIZEOP-1:0] i_opcode,
  input  logic              i_mem_ready,
  output logic              o_pc_write,
  output logic              o_ir_write,
  output logic              o_memread,
  output logic              o_memwrite,
  output logic              o_memtoreg,
  output logic              o_regdst,
  output logic              o_alusrc,
  output logic              o_regwrite,
  output logic              o_branch,
  output logic              o_jump,
  output logic [1:0]        o_aluop,
  output logic [2:0]        o_state,
  output logic              o_halted,
  output logic              o_invalid,
  output logic [CNTW-1:0]   o_retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    C_R, C_IALU, C_LW, C_SW, C_BEQ, C_J, C_HALT, C_BAD
  } cls_t;

  state_t state, next;
  cls_t   cls, dec_cls;
  logic   retire;

  function automatic cls_t classify(input logic [SIZEOP-1:0] op);
    cls_t c;
    c = C_BAD;
    if (op == SIZEOP'(6'b000000)) c = C_R;
    else if (op == SIZEOP'(6'b001000) || op == SIZEOP'(6'b001100) ||
             op == SIZEOP'(6'b001101) || op == SIZEOP'(6'b001110) ||
             op == SIZEOP'(6'b001111) || op == SIZEOP'(6'b001010)) c = C_IALU;
    else if (op == SIZEOP'(6'b100011)) c = C_LW;
    else if (op == SIZEOP'(6'b101011)) c = C_SW;
    else if (op == SIZEOP'(6'b000100)) c = C_BEQ;
    else if (op == SIZEOP'(6'b000010)) c = C_J;
    else if (op == SIZEOP'(6'b111111)) c = C_HALT;
    return c;
  endfunction

  function automatic logic [1:0] aluop_of(input cls_t c);
    logic [1:0] a;
    a = 2'b00;
    case (c)
      C_R:     a = 2'b10;
      C_IALU:  a = 2'b11;
      C_BEQ:   a = 2'b01;
      default: a = 2'b00;
    endcase
    return a;
  endfunction

  assign dec_cls = classify(i_opcode);

  // State register, latched class and retire counter; everything holds while frozen.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= S_IDLE;
      cls       <= C_BAD;
      o_aluop   <= 2'b00;
      o_retired <= '0;
    end else if (i_enable) begin
      state <= next;
      if (state == S_DECODE) begin
        cls     <= dec_cls;
        o_aluop <= aluop_of(dec_cls);
      end
      if (retire) o_retired <= o_retired + CNTW'(1);
    end
  end

  always_comb begin
    next   = state;
    retire = 1'b0;
    case (state)
      S_IDLE:  if (i_start) next = S_FETCH;
      S_FETCH: if (i_mem_ready) next = S_DECODE;
      S_DECODE: begin
        case (dec_cls)
          C_HALT:      next = S_HALT;
          C_J, C_BAD:  begin next = S_FETCH; retire = 1'b1; end
          default:     next = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (cls)
          C_BEQ:      begin next = S_FETCH; retire = 1'b1; end
          C_LW, C_SW: next = S_MEM;
          default:    next = S_WB;
        endcase
      end
      S_MEM: begin
        if (i_mem_ready) begin
          if (cls == C_SW) begin
            next   = S_FETCH;
            retire = 1'b1;
          end else begin
            next = S_WB;
          end
        end
      end
      S_WB:    begin next = S_FETCH; retire = 1'b1; end
      S_HALT:  next = S_HALT;
      default: next = S_IDLE;
    endcase
  end

  always_comb begin
    o_pc_write = 1'b0;
    o_ir_write = 1'b0;
    o_memread  = 1'b0;
    o_memwrite = 1'b0;
    o_memtoreg = 1'b0;
    o_regdst   = 1'b0;
    o_alusrc   = 1'b0;
    o_regwrite = 1'b0;
    o_branch   = 1'b0;
    o_jump     = 1'b0;
    o_invalid  = 1'b0;
    case (state)
      S_FETCH: begin
        o_memread = 1'b1;
        if (i_mem_ready) begin
          o_ir_write = 1'b1;
          o_pc_write = 1'b1;
        end
      end
      S_DECODE: begin
        if (dec_cls == C_J) begin
          o_jump     = 1'b1;
          o_pc_write = 1'b1;
        end
        if (dec_cls == C_BAD) o_invalid = 1'b1;
      end
      S_EXEC: begin
        o_alusrc = (cls == C_IALU) || (cls == C_LW) || (cls == C_SW);
        o_branch = (cls == C_BEQ);
      end
      S_MEM: begin
        o_memread  = (cls == C_LW);
        o_memwrite = (cls == C_SW);
      end
      S_WB: begin
        o_regwrite = 1'b1;
        o_memtoreg = (cls == C_LW);
        o_regdst   = (cls == C_R);
      end
      default: ;
    endcase
    // Reset also suppresses strobes so an abandoned instruction never writes.
    if (!i_enable || i_reset) begin
      o_pc_write = 1'b0;
      o_ir_write = 1'b0;
      o_memread  = 1'b0;
      o_memwrite = 1'b0;
      o_memtoreg = 1'b0;
      o_regdst   = 1'b0;
      o_alusrc   = 1'b0;
      o_regwrite = 1'b0;
      o_branch   = 1'b0;
      o_jump     = 1'b0;
      o_invalid  = 1'b0;
    end
  end

  assign o_state  = state;
  assign o_halted = (state == S_HALT);

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Self-checking bench for mips_multicycle_control: a directed vector table
// for the basic sequencing, freeze, invalid and HALT behaviour, plus
// hand-written sequences for wait states, latencies and mid-instruction reset.
module tb_mips_multicycle_control;

  logic        i_clk = 1'b0;
  logic        i_reset, i_start, i_enable, i_mem_ready;
  logic [5:0]  i_opcode;
  logic        o_pc_write, o_ir_write, o_memread, o_memwrite, o_memtoreg;
  logic        o_regdst, o_alusrc, o_regwrite, o_branch, o_jump;
  logic [1:0]  o_aluop;
  logic [2:0]  o_state;
  logic        o_halted, o_invalid;
  logic [31:0] o_retired;

  int checks = 0;
  int errors = 0;

  mips_multicycle_control #(.SIZEOP(6), .CNTW(32)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_enable(i_enable),
    .i_opcode(i_opcode), .i_mem_ready(i_mem_ready),
    .o_pc_write(o_pc_write), .o_ir_write(o_ir_write), .o_memread(o_memread),
    .o_memwrite(o_memwrite), .o_memtoreg(o_memtoreg), .o_regdst(o_regdst),
    .o_alusrc(o_alusrc), .o_regwrite(o_regwrite), .o_branch(o_branch),
    .o_jump(o_jump), .o_aluop(o_aluop), .o_state(o_state), .o_halted(o_halted),
    .o_invalid(o_invalid), .o_retired(o_retired)
  );

  always #5 i_clk = ~i_clk;

  // Strobe bit positions in the packed {pc,ir,mr,mw,mtr,rd,as,rw,br,jp} vector.
  localparam logic [9:0] PC  = 10'b1000000000;
  localparam logic [9:0] IR  = 10'b0100000000;
  localparam logic [9:0] MR  = 10'b0010000000;
  localparam logic [9:0] MW  = 10'b0001000000;
  localparam logic [9:0] RD  = 10'b0000010000;
  localparam logic [9:0] AS  = 10'b0000001000;
  localparam logic [9:0] RW  = 10'b0000000100;
  localparam logic [9:0] NON = 10'b0000000000;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_HALT = 6'b111111;
  localparam logic [5:0] OP_BAD  = 6'b010001;

  typedef struct {
    logic        start;
    logic        en;
    logic [5:0]  op;
    logic        rdy;
    logic [2:0]  e_state;
    logic [9:0]  e_str;
    logic [1:0]  e_aop;
    logic [31:0] e_ret;
    logic        e_inv;
    logic        e_halt;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [9:0] strobes();
    return {o_pc_write, o_ir_write, o_memread, o_memwrite, o_memtoreg,
            o_regdst, o_alusrc, o_regwrite, o_branch, o_jump};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic st, input logic en, input logic [5:0] op, input logic rdy,
                     input logic [2:0] es, input logic [9:0] estr, input logic [1:0] eaop,
                     input logic [31:0] eret, input logic einv, input logic ehalt);
    vec_t v;
    v.start = st; v.en = en; v.op = op; v.rdy = rdy;
    v.e_state = es; v.e_str = estr; v.e_aop = eaop; v.e_ret = eret;
    v.e_inv = einv; v.e_halt = ehalt;
    vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_reset = 1'b1; i_start = 1'b0; i_enable = 1'b1; i_mem_ready = 1'b0; i_opcode = OP_R;
    step();
    step();
    i_reset = 1'b0;
  endtask

  // Runs one instruction starting in FETCH until the next FETCH, with
  // `waits` not-ready cycles in MEM; records what the strobes did on the way.
  task automatic run_op(input logic [5:0] op, input int waits, output int cyc,
                        output logic [1:0] aop, output logic as_seen, output logic jp_seen,
                        output logic br_seen, output int mr_mem, output int mw_mem,
                        output logic mtr_seen);
    int mc;
    logic [2:0] prev;
    cyc = 0; mc = 0; aop = 2'bxx; as_seen = 0; jp_seen = 0; br_seen = 0;
    mr_mem = 0; mw_mem = 0; mtr_seen = 0;
    i_opcode = op;
    do begin
      if (o_state == 3'd4) begin
        i_mem_ready = (mc >= waits);
        mc++;
      end else begin
        i_mem_ready = 1'b1;
      end
      #1;
      if (o_alusrc) as_seen = 1;
      if (o_jump && o_state == 3'd2) jp_seen = 1;
      if (o_branch) br_seen = 1;
      if (o_state == 3'd4 && o_memread) mr_mem++;
      if (o_state == 3'd4 && o_memwrite) mw_mem++;
      if (o_state == 3'd5 && o_memtoreg && o_regwrite) mtr_seen = 1;
      prev = o_state;
      step();
      cyc++;
      if (prev == 3'd2) aop = o_aluop;
    end while (o_state != 3'd1 && cyc < 30);
  endtask

  initial begin
    int cyc, total, mr, mw;
    logic [1:0] aop;
    logic as_s, jp_s, br_s, mtr_s;
    logic [31:0] ret0;

    // start en op rdy | state strobes aluop retired invalid halted
    add(0, 1, OP_R,    0, 3'd0, NON,       2'b00, 0, 0, 0);
    add(1, 1, OP_R,    0, 3'd0, NON,       2'b00, 0, 0, 0);
    add(0, 1, OP_R,    1, 3'd1, PC|IR|MR,  2'b00, 0, 0, 0);
    add(0, 1, OP_R,    1, 3'd2, NON,       2'b00, 0, 0, 0);
    add(0, 1, OP_R,    1, 3'd3, NON,       2'b10, 0, 0, 0);
    add(0, 1, OP_R,    1, 3'd5, RW|RD,     2'b10, 0, 0, 0);
    add(0, 1, OP_ANDI, 1, 3'd1, PC|IR|MR,  2'b10, 1, 0, 0);
    add(0, 1, OP_ANDI, 1, 3'd2, NON,       2'b10, 1, 0, 0);
    add(0, 0, OP_ANDI, 1, 3'd3, NON,       2'b11, 1, 0, 0);
    add(0, 0, OP_ANDI, 1, 3'd3, NON,       2'b11, 1, 0, 0);
    add(0, 0, OP_ANDI, 1, 3'd3, NON,       2'b11, 1, 0, 0);
    add(0, 1, OP_ANDI, 1, 3'd3, AS,        2'b11, 1, 0, 0);
    add(0, 1, OP_ANDI, 1, 3'd5, RW,        2'b11, 1, 0, 0);
    add(0, 1, OP_BAD,  0, 3'd1, MR,        2'b11, 2, 0, 0);
    add(0, 0, OP_BAD,  1, 3'd1, NON,       2'b11, 2, 0, 0);
    add(0, 1, OP_BAD,  1, 3'd1, PC|IR|MR,  2'b11, 2, 0, 0);
    add(0, 1, OP_BAD,  1, 3'd2, NON,       2'b11, 2, 1, 0);
    add(0, 1, OP_HALT, 1, 3'd1, PC|IR|MR,  2'b00, 3, 0, 0);
    add(0, 1, OP_HALT, 1, 3'd2, NON,       2'b00, 3, 0, 0);
    add(1, 1, OP_HALT, 1, 3'd6, NON,       2'b00, 3, 0, 1);
    add(1, 1, OP_HALT, 1, 3'd6, NON,       2'b00, 3, 0, 1);

    do_reset();
    foreach (vecs[i]) begin
      i_start = vecs[i].start; i_enable = vecs[i].en;
      i_opcode = vecs[i].op;   i_mem_ready = vecs[i].rdy;
      #1;
      chk($sformatf("v%0d state", i),   32'(o_state),   32'(vecs[i].e_state));
      chk($sformatf("v%0d strobes", i), 32'(strobes()), 32'(vecs[i].e_str));
      chk($sformatf("v%0d aluop", i),   32'(o_aluop),   32'(vecs[i].e_aop));
      chk($sformatf("v%0d retired", i), o_retired,      vecs[i].e_ret);
      chk($sformatf("v%0d invalid", i), 32'(o_invalid), 32'(vecs[i].e_inv));
      chk($sformatf("v%0d halted", i),  32'(o_halted),  32'(vecs[i].e_halt));
      step();
    end

    // LW with two wait cycles in MEM.
    do_reset();
    i_start = 1'b1; step(); i_start = 1'b0;
    chk("lw start state", 32'(o_state), 32'd1);
    run_op(OP_LW, 2, cyc, aop, as_s, jp_s, br_s, mr, mw, mtr_s);
    chk("lw cycles", cyc, 7);
    chk("lw aluop", 32'(aop), 32'b00);
    chk("lw memread in mem", mr, 3);
    chk("lw memtoreg wb", 32'(mtr_s), 1);
    chk("lw alusrc", 32'(as_s), 1);
    chk("lw retired", o_retired, 1);

    // ADDI, BEQ, J, SW back to back with no waits.
    ret0 = o_retired;
    total = 0;
    run_op(OP_ADDI, 0, cyc, aop, as_s, jp_s, br_s, mr, mw, mtr_s);
    total += cyc;
    chk("addi cycles", cyc, 4);
    chk("addi aluop", 32'(aop), 32'b11);
    chk("addi alusrc", 32'(as_s), 1);
    run_op(OP_BEQ, 0, cyc, aop, as_s, jp_s, br_s, mr, mw, mtr_s);
    total += cyc;
    chk("beq cycles", cyc, 3);
    chk("beq aluop", 32'(aop), 32'b01);
    chk("beq branch", 32'(br_s), 1);
    chk("beq alusrc", 32'(as_s), 0);
    run_op(OP_J, 0, cyc, aop, as_s, jp_s, br_s, mr, mw, mtr_s);
    total += cyc;
    chk("j cycles", cyc, 2);
    chk("j jump", 32'(jp_s), 1);
    run_op(OP_SW, 0, cyc, aop, as_s, jp_s, br_s, mr, mw, mtr_s);
    total += cyc;
    chk("sw cycles", cyc, 4);
    chk("sw aluop", 32'(aop), 32'b00);
    chk("sw alusrc", 32'(as_s), 1);
    chk("sw memwrite", mw, 1);
    chk("seq total cycles", total, 13);
    chk("seq retired", o_retired - ret0, 4);

    // Reset while SW sits in MEM waiting for memory.
    i_opcode = OP_SW; i_mem_ready = 1'b1;
    step();
    step();
    i_mem_ready = 1'b0;
    step();
    chk("sw mem state", 32'(o_state), 32'd4);
    chk("sw mem memwrite", 32'(o_memwrite), 1);
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    chk("rst state", 32'(o_state), 32'd0);
    chk("rst memwrite", 32'(o_memwrite), 0);
    chk("rst retired", o_retired, 0);
    chk("rst aluop", 32'(o_aluop), 32'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
